pwm_capture: RTL

Receive-side counterpart of the pwm generator. Samples an incoming PWM line, measures period and high time in clock cycles, and computes integer duty cycle in percent. Also counts pulses per burst, so 8/16-pulse burst output from the generator can be checked in-system or looped back on the bench. Sits between an external/looped-back PWM pin and status/register logic.

---
 rtl/pwm_capture_if.sv | 39 +++
 rtl/pwm_capture.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: control and measurement bundle of the PWM capture block.
// master drives en/pwmIn; slave (the capture block) returns the results.
interface pwm_capture_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             pwmIn;
  logic [CNT_W-1:0] measPeriod;
  logic [CNT_W-1:0] measHigh;
  logic [7:0]       measDuty;
  logic             measValid;
  logic             overrun;
  logic [7:0]       burstLen;
  logic             burstDone;

  modport master (
    output en,
    output pwmIn,
    input  measPeriod,
    input  measHigh,
    input  measDuty,
    input  measValid,
    input  overrun,
    input  burstLen,
    input  burstDone
  );

  modport slave (
    input  en,
    input  pwmIn,
    output measPeriod,
    output measHigh,
    output measDuty,
    output measValid,
    output overrun,
    output burstLen,
    output burstDone
  );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures period/high time/duty and burst length of a PWM line.
// Optional glitch filter after the synchronizer: PWMCAP_GLITCH_FILTER_EN.
module pwm_capture #(
  parameter int CNT_W        = 16,
  parameter int IDLE_TIMEOUT = 1024,
  parameter int FILT_LEN     = 4
) (
  input  logic         clk,
  input  logic         rst,
  pwm_capture_if.slave bus
);

  localparam int DW  = CNT_W + 7;
  localparam int ITW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  if ((longint'(IDLE_TIMEOUT) >= (longint'(1) << CNT_W))
      || (IDLE_TIMEOUT < 1)) begin : gBadTimeout
    $error("pwm_capture: IDLE_TIMEOUT must lie in 1..2^CNT_W-1");
  end

  if (FILT_LEN < 1) begin : gBadFilt
    $error("pwm_capture: FILT_LEN must be at least 1");
  end

  logic             s1;
  logic             s2;
  logic             lvl;
  logic             lvlQ;
  logic             rise;
  logic             fall;

  state_t           state;
  state_t           stateNxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] highCnt;
  logic [CNT_W-1:0] idleTmr;
  logic [7:0]       pulseCnt;
  logic             tmrEnd;
  logic             latchHigh;
  logic             perDone;
  logic             toHit;

  logic             busy;
  logic             finish;
  logic             start;
  logic             ovf;
  logic             geq;
  logic [ITW-1:0]   iter;
  logic [DW-1:0]    quo;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] dvsr;
  logic [CNT_W-1:0] opHigh;
  logic [CNT_W:0]   remSh;

  logic [CNT_W-1:0] periodQ;
  logic [CNT_W-1:0] highQ;
  logic [7:0]       dutyQ;
  logic             validQ;
  logic             ovrQ;
  logic [7:0]       burstLenQ;
  logic             doneQ;

  // Two-flop synchronizer plus previous-level register for edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      lvlQ <= 1'b0;
    end else begin
      s1   <= bus.pwmIn;
      s2   <= s1;
      lvlQ <= lvl;
    end
  end

`ifdef PWMCAP_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);

  logic [FW-1:0] runCnt;
  logic          filtLvl;

  // Level follows the input only after FILT_LEN differing samples in a row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      runCnt  <= '0;
      filtLvl <= 1'b0;
    end else if (s2 == filtLvl) begin
      runCnt <= '0;
    end else if (runCnt == FW'(FILT_LEN - 1)) begin
      runCnt  <= '0;
      filtLvl <= s2;
    end else begin
      runCnt <= runCnt + 1'b1;
    end
  end

  assign lvl = filtLvl;
`else
  assign lvl = s2;
`endif

  assign rise   = lvl & ~lvlQ;
  assign fall   = ~lvl & lvlQ;
  assign tmrEnd = (idleTmr == CNT_W'(IDLE_TIMEOUT - 1));

  // Capture FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNxt;
    end
  end

  // Next state; an edge always beats a coincident timeout.
  always_comb begin
    stateNxt  = state;
    latchHigh = 1'b0;
    perDone   = 1'b0;
    toHit     = 1'b0;
    if (!bus.en) begin
      stateNxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (rise) stateNxt = HIGH;
        end
        HIGH: begin
          if (fall) begin
            stateNxt  = LOW;
            latchHigh = 1'b1;
          end else if (tmrEnd) begin
            stateNxt = IDLE;
            toHit    = 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            stateNxt = HIGH;
            perDone  = 1'b1;
          end else if (tmrEnd) begin
            stateNxt = IDLE;
            toHit    = 1'b1;
          end
        end
        default: stateNxt = IDLE;
      endcase
    end
  end

  // Width counter, idle timer and per-burst pulse counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      highCnt  <= '0;
      idleTmr  <= '0;
      pulseCnt <= '0;
    end else if (stateNxt == IDLE) begin
      cnt      <= '0;
      highCnt  <= '0;
      idleTmr  <= '0;
      pulseCnt <= '0;
    end else if (state == IDLE) begin
      cnt      <= CNT_W'(1);
      idleTmr  <= '0;
      pulseCnt <= 8'd1;
    end else begin
      if (perDone) begin
        cnt <= CNT_W'(1);
      end else if (cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
      idleTmr <= (rise | fall) ? '0 : idleTmr + 1'b1;
      if (perDone && (pulseCnt != 8'hFF)) begin
        pulseCnt <= pulseCnt + 1'b1;
      end
      if (latchHigh) begin
        highCnt <= cnt;
      end
    end
  end

  // Burst closes on idle timeout only; disable drops it silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      doneQ     <= 1'b0;
      burstLenQ <= '0;
    end else begin
      doneQ <= toHit && (pulseCnt != 8'd0);
      if (toHit && (pulseCnt != 8'd0)) begin
        burstLenQ <= pulseCnt;
      end
    end
  end

  assign finish = busy && (iter == ITW'(DW));
  assign start  = perDone && (!busy || finish);
  assign ovf    = perDone && busy && !finish;
  assign remSh  = {rem, quo[DW-1]};
  assign geq    = (remSh >= {1'b0, dvsr});

  // Restoring divider: highCnt*100 / period, one quotient bit per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy    <= 1'b0;
      iter    <= '0;
      quo     <= '0;
      rem     <= '0;
      dvsr    <= '0;
      opHigh  <= '0;
      periodQ <= '0;
      highQ   <= '0;
      dutyQ   <= '0;
      validQ  <= 1'b0;
      ovrQ    <= 1'b0;
    end else if (!bus.en) begin
      busy   <= 1'b0;
      iter   <= '0;
      quo    <= '0;
      rem    <= '0;
      dvsr   <= '0;
      opHigh <= '0;
      validQ <= 1'b0;
      ovrQ   <= 1'b0;
    end else begin
      validQ <= 1'b0;
      ovrQ   <= ovf;
      if (finish) begin
        periodQ <= dvsr;
        highQ   <= opHigh;
        dutyQ   <= quo[7:0];
        validQ  <= 1'b1;
        busy    <= 1'b0;
      end else if (busy) begin
        rem  <= geq ? CNT_W'(remSh - {1'b0, dvsr}) : remSh[CNT_W-1:0];
        quo  <= {quo[DW-2:0], geq};
        iter <= iter + 1'b1;
      end
      if (start) begin
        busy   <= 1'b1;
        iter   <= '0;
        rem    <= '0;
        quo    <= DW'(highCnt) * DW'(100);
        dvsr   <= cnt;
        opHigh <= highCnt;
      end
    end
  end

  assign bus.measPeriod = periodQ;
  assign bus.measHigh   = highQ;
  assign bus.measDuty   = dutyQ;
  assign bus.measValid  = validQ;
  assign bus.overrun    = ovrQ;
  assign bus.burstLen   = burstLenQ;
  assign bus.burstDone  = doneQ;

endmodule
